register_file: RTL
==================

Name: register_file

Overview:
- Architectural register file with rename tags; receiving end of the ROB commit interface (reg_done/reg_value/reg_id/reg_tag).
- On issue, records which ROB entry will produce each rd.
- Supplies rs1/rs2 value-or-tag to the issue stage combinationally.
- Drops all rename state on a ROB misprediction clear.

Parameters:
ROB_WIDTH, 4, width of ROB tags; must match ROB.
REG_WIDTH, 5, register index width; REG_NUM = 2**REG_WIDTH = 32 registers.

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  ready; state frozen when low
clear_signal  input  1  ROB misprediction flush
issue_signal  input  1  instruction issued this cycle
issue_rd_id  input  REG_WIDTH  destination register of issued instruction
issue_tag  input  ROB_WIDTH  ROB entry allocated to issued instruction (ROB rob_tag)
rs1_id  input  REG_WIDTH  source register 1 index
rs2_id  input  REG_WIDTH  source register 2 index
rs1_busy  output  1  1: value pending, use rs1_tag
rs1_value  output  32  register value (valid when rs1_busy=0)
rs1_tag  output  ROB_WIDTH  producing ROB tag (valid when rs1_busy=1)
rs2_busy, rs2_value, rs2_tag  output  1/32/ROB_WIDTH  same for rs2
reg_done  input  1  ROB commit strobe
reg_value  input  32  committed value
reg_id  input  REG_WIDTH  committed rd
reg_tag  input  ROB_WIDTH  ROB entry being committed

Behaviour:
- State per register: value[31:0], busy, tag. The clock is clk_in; rst_in is synchronous, active-high.
- Reset: all value=0, busy=0, tag=0. Reads after reset therefore give busy=0, value=0, tag=0. Reset has priority over everything, including rdy_in=0.
- rdy_in=0: no state change. Read outputs remain combinationally valid.
- x0: always reads value=0, busy=0, tag=0. Issue and commit to x0 are ignored.
- Commit (rdy_in & reg_done & reg_id!=0), takes effect next edge:
  - value[reg_id] <= reg_value.
  - busy[reg_id] <= 0 only if busy[reg_id] & tag[reg_id]==reg_tag. Otherwise a newer rename stays busy.
- Issue (rdy_in & issue_signal & issue_rd_id!=0 & ~clear_signal): busy[rd] <= 1; tag[rd] <= issue_tag.
- Same edge, commit and issue to the same register:
  - value is written from the commit.
  - busy=1 and tag=issue_tag from the issue (issue wins).
- Clear (rdy_in & clear_signal):
  - All busy <= 0; tags are don't-care.
  - Issue in the same cycle is discarded.
  - A concurrent commit still writes value.
- Read ports are combinational, with commit bypass:
  - If reg_done & reg_id==rsX_id & rsX_id!=0 & busy[rsX] & tag[rsX]==reg_tag, then rsX_busy=0 and rsX_value=reg_value.
  - Otherwise the outputs show stored state.
  - Same-cycle issue is not forwarded to reads: the reader is the issuing instruction, and its own rd must not alias its rs.
  - Bypass is gated only by reg_done, not by rdy_in.
- Latency: write-to-read is 0 cycles via bypass and 1 cycle via stored state.

Optional Feature:
- Macro RF_COMMIT_CNT_EN.
- Defined: adds output commit_count[31:0]. It resets to 0 and increments by 1 on each edge with rdy_in & reg_done & reg_id!=0. It wraps from 32'hFFFFFFFF to 0 and is unaffected by clear_signal.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared header holds ROB_WIDTH and REG_WIDTH defaults, plus the instruction-class defines REG_INSTR, STORE_INSTR, BRANCH_INSTR and LOAD_INSTR, used by ROB, issue and RF.
- One sub-module, rf_read_port, instantiated twice: a combinational x0/bypass/select mux from the stored arrays and commit inputs to busy/value/tag.

Test Plan:
- Reset, then read x5 -> rs1_busy=0, rs1_value=0, rs1_tag=0.
- Issue rd=5, tag=3; next cycle commit id=5, tag=3, value=32'hDEADBEEF with rs1_id=5:
  - issue cycle+1 -> busy=1, tag=3;
  - commit cycle -> bypass gives busy=0, value=DEADBEEF;
  - cycle after -> stored value DEADBEEF, busy=0.
- Issue rd=7 tag=2, then issue rd=7 tag=6, then commit id=7 tag=2 value=11 -> value[7]=11, busy stays 1, tag=6, and the read does not bypass.
- Same edge: commit id=9 tag=1 value=42 and issue rd=9 tag=4 -> next cycle busy=1, tag=4, stored value 42.
- Busy on x3 and x8, then clear_signal with issue rd=10 -> next cycle x3, x8 and x10 all busy=0. Issue and commit to x0 leave x0 reading 0.
- rdy_in=0 with issue rd=4 and commit id=4 -> no state change. With RF_COMMIT_CNT_EN, 3 non-x0 commits under rdy_in=1 -> commit_count=3.

Source files
------------

// File: rtl/register_file_pkg.sv
// register_file_pkg: shared widths and instruction classes for ROB, issue and register file.
package register_file_pkg;
   localparam int DEF_ROB_WIDTH = 4;
   localparam int DEF_REG_WIDTH = 5;
   typedef enum logic [1:0] {
      REG_INSTR,
      STORE_INSTR,
      BRANCH_INSTR,
      LOAD_INSTR
   } instr_class_e;
endpackage

// File: rtl/register_file_read_port.sv
// rf_read_port: x0 forcing and commit bypass over one selected register entry.
module rf_read_port
   import register_file_pkg::*;
#(
   parameter int ROB_WIDTH = DEF_ROB_WIDTH,
   parameter int REG_WIDTH = DEF_REG_WIDTH
) (
   input  logic [REG_WIDTH-1:0] rs_id,
   input  logic                 st_busy,
   input  logic [31:0]          st_value,
   input  logic [ROB_WIDTH-1:0] st_tag,
   input  logic                 reg_done,
   input  logic [REG_WIDTH-1:0] reg_id,
   input  logic [31:0]          reg_value,
   input  logic [ROB_WIDTH-1:0] reg_tag,
   output logic                 rs_busy,
   output logic [31:0]          rs_value,
   output logic [ROB_WIDTH-1:0] rs_tag
);
   logic w_zero, w_byp;
   assign w_zero = rs_id == '0;
   // only the rename still outstanding may be satisfied by this commit
   assign w_byp = reg_done && reg_id == rs_id && !w_zero && st_busy && st_tag == reg_tag;
   always_comb begin
      rs_busy  = (w_zero || w_byp) ? 1'b0 : st_busy;
      rs_value = w_zero ? 32'd0 : (w_byp ? reg_value : st_value);
      rs_tag   = w_zero ? '0 : st_tag;
   end
endmodule

// File: rtl/register_file.sv
// register_file: architectural registers with ROB rename tags and commit bypass.
// Optional commit_count output enabled by defining RF_COMMIT_CNT_EN.
module register_file
   import register_file_pkg::*;
#(
   parameter int ROB_WIDTH = DEF_ROB_WIDTH,
   parameter int REG_WIDTH = DEF_REG_WIDTH
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clear_signal,
   input  logic                 issue_signal,
   input  logic [REG_WIDTH-1:0] issue_rd_id,
   input  logic [ROB_WIDTH-1:0] issue_tag,
   input  logic [REG_WIDTH-1:0] rs1_id,
   input  logic [REG_WIDTH-1:0] rs2_id,
   output logic                 rs1_busy,
   output logic [31:0]          rs1_value,
   output logic [ROB_WIDTH-1:0] rs1_tag,
   output logic                 rs2_busy,
   output logic [31:0]          rs2_value,
   output logic [ROB_WIDTH-1:0] rs2_tag,
   input  logic                 reg_done,
   input  logic [31:0]          reg_value,
   input  logic [REG_WIDTH-1:0] reg_id,
   input  logic [ROB_WIDTH-1:0] reg_tag
`ifdef RF_COMMIT_CNT_EN
   ,output logic [31:0]         commit_count
`endif
);
   localparam int REG_NUM = 2**REG_WIDTH;
   logic [31:0]          r_value [REG_NUM];
   logic                 r_busy  [REG_NUM];
   logic [ROB_WIDTH-1:0] r_tag   [REG_NUM];
   logic                 w_commit, w_issue;
   assign w_commit = rdy_in && reg_done && reg_id != '0;
   assign w_issue  = rdy_in && issue_signal && issue_rd_id != '0 && !clear_signal;
   // issue outranks commit on busy/tag so a newer rename is never lost
   always_ff @(posedge clk_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
         if (rst_in) begin
            r_value[i] <= 32'd0;
            r_busy[i]  <= 1'b0;
            r_tag[i]   <= '0;
         end else if (rdy_in) begin
            if (w_commit && reg_id == REG_WIDTH'(i)) r_value[i] <= reg_value;
            if (clear_signal) r_busy[i] <= 1'b0;
            else if (w_issue && issue_rd_id == REG_WIDTH'(i)) begin
               r_busy[i] <= 1'b1;
               r_tag[i]  <= issue_tag;
            end else if (w_commit && reg_id == REG_WIDTH'(i) && r_tag[i] == reg_tag)
               r_busy[i] <= 1'b0;
         end
      end
   end
`ifdef RF_COMMIT_CNT_EN
   logic [31:0] r_commit_count;
   always_ff @(posedge clk_in) begin
      if (rst_in) r_commit_count <= 32'd0;
      else if (w_commit) r_commit_count <= r_commit_count + 32'd1;
   end
   assign commit_count = r_commit_count;
`endif
   rf_read_port #(.ROB_WIDTH(ROB_WIDTH), .REG_WIDTH(REG_WIDTH)) u_rs1 (
      .rs_id(rs1_id), .st_busy(r_busy[rs1_id]), .st_value(r_value[rs1_id]), .st_tag(r_tag[rs1_id]),
      .reg_done(reg_done), .reg_id(reg_id), .reg_value(reg_value), .reg_tag(reg_tag),
      .rs_busy(rs1_busy), .rs_value(rs1_value), .rs_tag(rs1_tag)
   );
   rf_read_port #(.ROB_WIDTH(ROB_WIDTH), .REG_WIDTH(REG_WIDTH)) u_rs2 (
      .rs_id(rs2_id), .st_busy(r_busy[rs2_id]), .st_value(r_value[rs2_id]), .st_tag(r_tag[rs2_id]),
      .reg_done(reg_done), .reg_id(reg_id), .reg_value(reg_value), .reg_tag(reg_tag),
      .rs_busy(rs2_busy), .rs_value(rs2_value), .rs_tag(rs2_tag)
   );
endmodule
